adderw3_arbiter: RTL

Round-robin arbiter and pipeline controller that shares one pipelined 3-input saturating W-bit adder among N requesters in the decoder datapath, such as node-update units in different lanes. Each requester presents three signed operands with a valid/ready handshake. The block grants one requester per cycle, runs the 2's-complement 3-operand add with clamp-to-range saturation, and returns the result tagged with the requester index through a backpressured result port. It also keeps a saturation-event counter for LLR range monitoring.

---
 rtl/adderw3_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/adderw3_arbiter.sv
// rtl/adderw3_arbiter.sv - round-robin arbiter sharing a 2-stage saturating 3-input adder
// Grants one of N requesters per cycle and returns a tagged, clamped sum with backpressure.
module adderw3_arbiter #(
   parameter  int W    = 10,
   parameter  int N    = 4,
   parameter  int CNTW = 16,
   localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [N*W-1:0]    req_a,
   input  logic [N*W-1:0]    req_b,
   input  logic [N*W-1:0]    req_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic [IDW-1:0]    res_id,
   output logic              res_sat,
   output logic [CNTW-1:0]   sat_count,
   input  logic              clr_stats
);

   logic [IDW-1:0]  r_ptr;
   logic            r_s1_valid;
   logic [IDW-1:0]  r_s1_id;
   logic [W+1:0]    r_raw;
   logic            r_res_valid;
   logic [W-1:0]    r_res_sum;
   logic [IDW-1:0]  r_res_id;
   logic            r_res_sat;
   logic [CNTW-1:0] r_sat_count;

   logic            w_adv;
   logic            w_any;
   logic            w_hs;
   logic [IDW-1:0]  w_gnt;
   logic [IDW-1:0]  w_scan;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [W-1:0]    w_c;
   logic [W+1:0]    w_sum;
   logic [W-1:0]    w_sat_sum;
   logic            w_sat;

   assign w_adv = !r_res_valid || res_ready;

   // Scan from the far end back toward ptr so the closest valid requester wins.
   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      w_scan = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_scan = IDW'((int'(r_ptr) + k) % N);
         if (req_valid[w_scan]) begin
            w_any = 1'b1;
            w_gnt = w_scan;
         end
      end
   end

   assign w_hs      = rst && w_adv && w_any;
   assign req_ready = w_hs ? (N'(1) << w_gnt) : '0;

   always_comb begin
      w_a = '0;
      w_b = '0;
      w_c = '0;
      for (int i = 0; i < N; i++) begin
         if (w_gnt == IDW'(i)) begin
            w_a = req_a[i*W +: W];
            w_b = req_b[i*W +: W];
            w_c = req_c[i*W +: W];
         end
      end
   end

   // Two guard bits make the three-way sum exact.
   assign w_sum = {{2{w_a[W-1]}}, w_a} + {{2{w_b[W-1]}}, w_b} + {{2{w_c[W-1]}}, w_c};

   always_comb begin
      w_sat_sum = r_raw[W-1:0];
      w_sat     = 1'b0;
      case (r_raw[W+1:W-1])
         3'b000, 3'b111: begin
            w_sat_sum = r_raw[W-1:0];
            w_sat     = 1'b0;
         end
         3'b001, 3'b010, 3'b011: begin
            w_sat_sum = {1'b0, {(W-1){1'b1}}};
            w_sat     = 1'b1;
         end
         default: begin
            w_sat_sum = {1'b1, {(W-1){1'b0}}};
            w_sat     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr       <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_id     <= '0;
         r_raw       <= '0;
         r_res_valid <= 1'b0;
         r_res_sum   <= '0;
         r_res_id    <= '0;
         r_res_sat   <= 1'b0;
         r_sat_count <= '0;
      end else begin
         if (w_adv) begin
            r_s1_valid  <= w_hs;
            r_s1_id     <= w_gnt;
            r_raw       <= w_sum;
            r_res_valid <= r_s1_valid;
            r_res_sum   <= w_sat_sum;
            r_res_id    <= r_s1_id;
            r_res_sat   <= w_sat;
         end
         if (w_hs) begin
            r_ptr <= IDW'((int'(w_gnt) + 1) % N);
         end
         // Clear beats a same-cycle increment; the counter sticks at all-ones.
         if (clr_stats) begin
            r_sat_count <= '0;
         end else if (r_res_valid && res_ready && r_res_sat && !(&r_sat_count)) begin
            r_sat_count <= r_sat_count + 1'b1;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_sum   = r_res_sum;
   assign res_id    = r_res_id;
   assign res_sat   = r_res_sat;
   assign sat_count = r_sat_count;

endmodule
